lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 117 +++++++++++
 tb/tb_lfsr_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 8-bit Galois LFSR pattern
// generator (x^8+x^4+x^3+x^2+1). It reseeds from incoming data while
// searching, locks after a run of consecutive matches, then free-runs and
// counts mismatching words in a saturating error counter.
module lfsr_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  input  logic             i_clr_err,
  output logic             o_lock,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_count,
  output logic [7:0]       o_expected
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    match_q, match_d;
  logic [UW-1:0]    miss_q, miss_d;
  logic [7:0]       exp_d;
  logic             err_d;
  logic [ERR_W-1:0] cnt_d;
  logic             is_match;
  logic             count_err;

  // One step of the generator polynomial in Galois form; feedback is bit 7.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic f;
    f = s[7];
    return {s[6], s[5], s[4], s[3] ^ f, s[2] ^ f, s[1] ^ f, s[0], f};
  endfunction

  // All-zero is the LFSR lock-up word, so it can never count as a match.
  assign is_match = (i_data == o_expected) && (i_data != 8'h00);
  assign o_lock   = (state_q == LOCKED);

  // Next-state logic: reseed while searching, free-run while locked, and
  // track consecutive match/miss runs plus the saturating error count.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    miss_d    = miss_q;
    exp_d     = o_expected;
    err_d     = 1'b0;
    cnt_d     = o_err_count;
    count_err = 1'b0;
    if (i_valid) begin
      case (state_q)
        SEARCH: begin
          exp_d = lfsr_next(i_data);
          if (is_match) begin
            match_d = match_q + MW'(1);
            if (match_q == MW'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          exp_d = lfsr_next(o_expected);
          if (is_match) begin
            miss_d = '0;
          end else begin
            err_d     = 1'b1;
            count_err = 1'b1;
            miss_d    = miss_q + UW'(1);
            if (miss_q == UW'(UNLOCK_COUNT - 1)) begin
              state_d = SEARCH;
              match_d = '0;
              exp_d   = lfsr_next(i_data);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (i_clr_err) begin
      cnt_d = count_err ? ERR_W'(1) : '0;
    end else if (count_err && (o_err_count != {ERR_W{1'b1}})) begin
      cnt_d = o_err_count + ERR_W'(1);
    end
  end

  // State and output registers; reset returns to an unlocked, zeroed checker.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= SEARCH;
      match_q     <= '0;
      miss_q      <= '0;
      o_expected  <= 8'h00;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      o_expected  <= exp_d;
      o_err       <= err_d;
      o_err_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus a random
// stream, compared against a word-level behavioural model. A second instance
// with a 4-bit error counter exercises saturation alongside the default one.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_clr_err = 1'b0;
  logic        o_lock, o_err, o_lock4, o_err4;
  logic [15:0] o_err_count;
  logic [3:0]  o_err_count4;
  logic [7:0]  o_expected, o_expected4;

  int checks = 0;
  int failures = 0;

  // Behavioural model state (plain integers, one update per clock edge)
  int m_lock, m_exp, m_err, m_cnt16, m_cnt4, m_run, m_miss;

  lfsr_checker dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_clr_err(i_clr_err), .o_lock(o_lock), .o_err(o_err),
    .o_err_count(o_err_count), .o_expected(o_expected)
  );

  lfsr_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_clr_err(i_clr_err), .o_lock(o_lock4), .o_err(o_err4),
    .o_err_count(o_err_count4), .o_expected(o_expected4)
  );

  always #5 clk = ~clk;

  // Shift left, fold the dropped top bit back in as the 0x1D tap mask
  function automatic int lfsr_ref(input int s);
    return ((s << 1) & 255) ^ (((s & 128) != 0) ? 8'h1D : 0);
  endfunction

  task automatic model_update(input logic v, input int d, input logic c, input logic r);
    int err_now;
    err_now = 0;
    if (r) begin
      m_lock = 0; m_exp = 0; m_err = 0; m_cnt16 = 0; m_cnt4 = 0; m_run = 0; m_miss = 0;
      return;
    end
    if (v) begin
      if (m_lock == 0) begin
        if (d == m_exp && d != 0) begin
          m_run++;
          if (m_run >= 4) begin m_lock = 1; m_miss = 0; end
        end else m_run = 0;
        m_exp = lfsr_ref(d);
      end else if (d == m_exp && d != 0) begin
        m_miss = 0;
        m_exp = lfsr_ref(m_exp);
      end else begin
        err_now = 1;
        m_miss++;
        if (m_miss >= 3) begin m_lock = 0; m_run = 0; m_exp = lfsr_ref(d); end
        else m_exp = lfsr_ref(m_exp);
      end
    end
    m_err = err_now;
    if (c) begin
      m_cnt16 = err_now; m_cnt4 = err_now;
    end else if (err_now != 0) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    i_valid = v; i_data = d; i_clr_err = c; i_rst = r;
    @(posedge clk);
    model_update(v, int'(d), c, r);
    #1;
    i_valid = 1'b0; i_clr_err = 1'b0; i_rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (o_lock !== 1'b0) begin failures++; $display("[TB] FAIL reset_lock got=%0b exp=0", o_lock); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", o_err); end
    checks++; if (o_err_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", o_err_count); end
    checks++; if (o_err_count4 !== 4'd0) begin failures++; $display("[TB] FAIL reset_count4 got=%0d exp=0", o_err_count4); end
    checks++; if (o_expected !== 8'h00) begin failures++; $display("[TB] FAIL reset_expected got=%0h exp=00", o_expected); end
  endtask

  task automatic test_lock_acquire();
    logic [7:0] words [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0);
      checks++; if (o_lock !== (i >= 4)) begin failures++; $display("[TB] FAIL acquire_lock word=%0d got=%0b exp=%0b", i, o_lock, (i >= 4)); end
      checks++; if (o_expected !== 8'(m_exp)) begin failures++; $display("[TB] FAIL acquire_expected word=%0d got=%0h exp=%0h", i, o_expected, m_exp); end
      if (i == 4) begin
        checks++; if (o_expected !== 8'h20) begin failures++; $display("[TB] FAIL acquire_exp20 got=%0h exp=20", o_expected); end
      end
    end
    checks++; if (o_expected !== 8'h1D) begin failures++; $display("[TB] FAIL acquire_exp1d got=%0h exp=1d", o_expected); end
    checks++; if (o_err_count !== 16'd0) begin failures++; $display("[TB] FAIL acquire_count got=%0d exp=0", o_err_count); end
  endtask

  task automatic test_err_pulse();
    step(1'b1, 8'h1D, 1'b0, 1'b0);
    checks++; if (o_expected !== 8'h3A) begin failures++; $display("[TB] FAIL pulse_exp3a got=%0h exp=3a", o_expected); end
    step(1'b1, 8'h3B, 1'b0, 1'b0);
    checks++; if (o_err !== 1'b1) begin failures++; $display("[TB] FAIL pulse_err_high got=%0b exp=1", o_err); end
    checks++; if (o_err_count !== 16'd1) begin failures++; $display("[TB] FAIL pulse_count got=%0d exp=1", o_err_count); end
    checks++; if (o_lock !== 1'b1) begin failures++; $display("[TB] FAIL pulse_lock got=%0b exp=1", o_lock); end
    checks++; if (o_expected !== 8'h74) begin failures++; $display("[TB] FAIL pulse_exp74 got=%0h exp=74", o_expected); end
    step(1'b1, 8'h74, 1'b0, 1'b0);
    checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL pulse_err_low got=%0b exp=0", o_err); end
    checks++; if (o_err_count !== 16'd1) begin failures++; $display("[TB] FAIL pulse_count_hold got=%0d exp=1", o_err_count); end
    checks++; if (o_expected !== 8'hE8) begin failures++; $display("[TB] FAIL pulse_freerun got=%0h exp=e8", o_expected); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (o_expected !== 8'hE8 || o_err !== 1'b0) begin failures++; $display("[TB] FAIL pulse_idle got=%0h/%0b exp=e8/0", o_expected, o_err); end
  endtask

  task automatic test_unlock_relock();
    int base, seed;
    logic [7:0] w;
    base = m_cnt16;
    for (int k = 0; k < 3; k++) begin
      w = 8'(m_exp ^ int'($urandom_range(1, 255)));
      step(1'b1, w, 1'b0, 1'b0);
      checks++; if (o_err !== 1'b1) begin failures++; $display("[TB] FAIL unlock_err k=%0d got=%0b exp=1", k, o_err); end
      checks++; if (o_lock !== (k < 2)) begin failures++; $display("[TB] FAIL unlock_lock k=%0d got=%0b exp=%0b", k, o_lock, (k < 2)); end
      checks++; if (int'(o_err_count) != base + k + 1) begin failures++; $display("[TB] FAIL unlock_count k=%0d got=%0d exp=%0d", k, o_err_count, base + k + 1); end
    end
    checks++; if (o_expected !== 8'(m_exp)) begin failures++; $display("[TB] FAIL unlock_reseed got=%0h exp=%0h", o_expected, m_exp); end
    do seed = int'($urandom_range(1, 255)); while (seed == m_exp);
    w = 8'(seed);
    for (int j = 0; j < 5; j++) begin
      step(1'b1, w, 1'b0, 1'b0);
      checks++; if (o_lock !== (j == 4)) begin failures++; $display("[TB] FAIL relock j=%0d got=%0b exp=%0b", j, o_lock, (j == 4)); end
      checks++; if (o_err !== 1'b0) begin failures++; $display("[TB] FAIL relock_err j=%0d got=%0b exp=0", j, o_err); end
      w = 8'(lfsr_ref(int'(w)));
    end
    checks++; if (int'(o_err_count) != base + 3) begin failures++; $display("[TB] FAIL relock_count got=%0d exp=%0d", o_err_count, base + 3); end
  endtask

  task automatic test_zero_words();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (o_lock !== 1'b0 || o_expected !== 8'h00 || o_err !== 1'b0) begin
        failures++; $display("[TB] FAIL zero_words i=%0d got lock=%0b exp=%0h err=%0b, required 0/00/0", i, o_lock, o_expected, o_err);
      end
    end
  endtask

  task automatic test_idle_gaps();
    logic [7:0] w;
    logic [7:0] held;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    w = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w, 1'b0, 1'b0);
      checks++; if (o_lock !== (i == 4)) begin failures++; $display("[TB] FAIL gaps_lock i=%0d got=%0b exp=%0b", i, o_lock, (i == 4)); end
      held = 8'(lfsr_ref(int'(w)));
      repeat ($urandom_range(1, 3)) begin
        step(1'b0, 8'($urandom), 1'b0, 1'b0);
        checks++; if (o_expected !== held) begin failures++; $display("[TB] FAIL gaps_hold i=%0d got=%0h exp=%0h", i, o_expected, held); end
      end
      w = held;
    end
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 8'(m_exp), 1'b0, 1'b0);
      step(1'b1, 8'(m_exp ^ int'($urandom_range(1, 255))), 1'b0, 1'b0);
      checks++; if (int'(o_err_count4) != ((n < 15) ? n : 15)) begin failures++; $display("[TB] FAIL sat_count4 n=%0d got=%0d exp=%0d", n, o_err_count4, (n < 15) ? n : 15); end
      checks++; if (int'(o_err_count) != n) begin failures++; $display("[TB] FAIL sat_count16 n=%0d got=%0d exp=%0d", n, o_err_count, n); end
      checks++; if (o_lock4 !== 1'b1 || o_err4 !== 1'b1) begin failures++; $display("[TB] FAIL sat_lock n=%0d got lock=%0b err=%0b exp=1/1", n, o_lock4, o_err4); end
    end
    step(1'b1, 8'(m_exp), 1'b0, 1'b0);
    step(1'b1, 8'(m_exp ^ 8'h5A), 1'b1, 1'b0);
    checks++; if (o_err_count !== 16'd1 || o_err_count4 !== 4'd1) begin failures++; $display("[TB] FAIL clr_with_err got=%0d/%0d exp=1/1", o_err_count, o_err_count4); end
    checks++; if (o_err !== 1'b1 || o_lock !== 1'b1) begin failures++; $display("[TB] FAIL clr_with_err_flags got err=%0b lock=%0b exp=1/1", o_err, o_lock); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (o_err_count !== 16'd0 || o_err_count4 !== 4'd0) begin failures++; $display("[TB] FAIL clr_alone got=%0d/%0d exp=0/0", o_err_count, o_err_count4); end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'(m_exp), 1'b1, 1'b1);
    checks++; if (o_lock !== 1'b0 || o_err !== 1'b0 || o_err_count !== 16'd0 || o_expected !== 8'h00) begin
      failures++; $display("[TB] FAIL midstream_reset got lock=%0b err=%0b cnt=%0d exp=%0h, required 0/0/0/00", o_lock, o_err, o_err_count, o_expected);
    end
  endtask

  task automatic test_random();
    logic v, c;
    logic [7:0] d;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom % 4) != 0;
      d = (($urandom % 8) != 0 && m_exp != 0) ? 8'(m_exp) : 8'($urandom);
      c = ($urandom % 32) == 0;
      step(v, d, c, 1'b0);
      checks++;
      if (o_lock !== 1'(m_lock) || o_err !== 1'(m_err) || o_expected !== 8'(m_exp) ||
          int'(o_err_count) != m_cnt16 || int'(o_err_count4) != m_cnt4) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d got lock=%0b err=%0b exp=%0h cnt=%0d cnt4=%0d required %0d/%0d/%0h/%0d/%0d",
                 cyc, o_lock, o_err, o_expected, o_err_count, o_err_count4, m_lock, m_err, m_exp, m_cnt16, m_cnt4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_err_pulse();
    test_unlock_relock();
    test_zero_words();
    test_idle_gaps();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
